// File: rtl/llc_mem_responder_pkg.sv
// Shared cache constants/types plus the memory responder state encoding.
package llc_mem_responder_pkg;

  localparam int unsigned LINE_ADDR_BITS = 16;
  localparam int unsigned BITS_PER_LINE  = 128;
  localparam int unsigned HSIZE_WIDTH    = 3;
  localparam int unsigned HPROT_WIDTH    = 2;

  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [BITS_PER_LINE-1:0]  line_t;
  typedef logic [HSIZE_WIDTH-1:0]    hsize_t;
  typedef logic [HPROT_WIDTH-1:0]    hprot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2,
    WR_WAIT = 2'd3
  } mem_rsp_state_t;

  // Request payload captured on accept
  typedef struct packed {
    logic       hwrite;
    hsize_t     hsize;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
  } mem_req_t;

endpackage

// File: rtl/llc_mem_array.sv
// Line-granular backing store: synchronous write, combinational read,
// per-line written bits so never-written lines read as zero.
module llc_mem_array
  import llc_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LINES = 256,
  localparam int unsigned IDX_W    = $clog2(MEM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  line_t            wr_line,
  output line_t            rd_line_c
);

  logic [MEM_LINES-1:0] written_q;
  logic [MEM_LINES-1:0] written_d;
  line_t                mem_q [MEM_LINES];

  always_comb begin
    written_d = written_q;
    if (we) written_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) written_q <= '0;
    else      written_q <= written_d;
  end

  // Contents survive reset; only the written bits are cleared
  always_ff @(posedge clk) begin
    if (rst && we) mem_q[idx] <= wr_line;
  end

  assign rd_line_c = written_q[idx] ? mem_q[idx] : '0;

endmodule

// File: rtl/llc_mem_responder.sv
// LLC memory-side responder with fixed read/write latency.
// Optional macro LLC_MEM_RSP_STATS_EN adds rd_count/wr_count ports.
module llc_mem_responder
  import llc_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LINES  = 256,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       llc_mem_req_valid,
  output logic       llc_mem_req_ready,
  input  logic       llc_mem_req_data_hwrite,
  input  hsize_t     llc_mem_req_data_hsize,
  input  hprot_t     llc_mem_req_data_hprot,
  input  line_addr_t llc_mem_req_data_addr,
  input  line_t      llc_mem_req_data_line,
  output logic       llc_mem_rsp_valid,
  input  logic       llc_mem_rsp_ready,
`ifdef LLC_MEM_RSP_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  output line_t      llc_mem_rsp_data_line
);

  localparam int unsigned IDX_W   = $clog2(MEM_LINES);
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  mem_rsp_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  line_t            rsp_line_q, rsp_line_d;
  logic             we_c;
  logic             rd_hs_c;
  line_t            rd_line_c;
  logic             unused_req_c;

  llc_mem_array #(.MEM_LINES(MEM_LINES)) u_array (
    .clk       (clk),
    .rst       (rst),
    .we        (we_c),
    .idx       (req_q.addr[IDX_W-1:0]),
    .wr_line   (req_q.line),
    .rd_line_c (rd_line_c)
  );

  // hsize/hprot and upper address bits are captured but not consumed
  assign unused_req_c = ^{req_q.hsize, req_q.hprot, req_q.addr};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rsp_line_d = rsp_line_q;
    we_c       = 1'b0;
    rd_hs_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (llc_mem_req_valid && ready_q) begin
          req_d.hwrite = llc_mem_req_data_hwrite;
          req_d.hsize  = llc_mem_req_data_hsize;
          req_d.hprot  = llc_mem_req_data_hprot;
          req_d.addr   = llc_mem_req_data_addr;
          req_d.line   = llc_mem_req_data_line;
          if (llc_mem_req_data_hwrite) begin
            state_d = WR_WAIT;
            cnt_d   = CNT_W'(WR_LATENCY - 1);
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RSP;
          rsp_line_d = rd_line_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RSP: begin
        if (rsp_valid_q && llc_mem_rsp_ready) begin
          state_d = IDLE;
          rd_hs_c = 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          we_c    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_line_q  <= rsp_line_d;
    end
  end

  assign llc_mem_req_ready     = ready_q;
  assign llc_mem_rsp_valid     = rsp_valid_q;
  assign llc_mem_rsp_data_line = rsp_line_q;

`ifdef LLC_MEM_RSP_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q + 32'(rd_hs_c);
    wr_count_d = wr_count_q + 32'(we_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_llc_mem_responder.sv
// Directed self-checking bench for llc_mem_responder (default parameters).
module tb_llc_mem_responder;
  import llc_mem_responder_pkg::*;

  localparam int unsigned RD_LAT = 4;
  localparam int unsigned WR_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_hwrite;
  hsize_t     req_hsize;
  hprot_t     req_hprot;
  line_addr_t req_addr;
  line_t      req_line;
  logic       rsp_valid;
  logic       rsp_ready;
  line_t      rsp_line;
`ifdef LLC_MEM_RSP_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  llc_mem_responder #(.MEM_LINES(256), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .llc_mem_req_valid       (req_valid),
    .llc_mem_req_ready       (req_ready),
    .llc_mem_req_data_hwrite (req_hwrite),
    .llc_mem_req_data_hsize  (req_hsize),
    .llc_mem_req_data_hprot  (req_hprot),
    .llc_mem_req_data_addr   (req_addr),
    .llc_mem_req_data_line   (req_line),
    .llc_mem_rsp_valid       (rsp_valid),
    .llc_mem_rsp_ready       (rsp_ready),
`ifdef LLC_MEM_RSP_STATS_EN
    .rd_count                (rd_count),
    .wr_count                (wr_count),
`endif
    .llc_mem_rsp_data_line   (rsp_line)
  );

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_ready", line_t'(req_ready), '0);
    chk("rst_rsp_valid", line_t'(rsp_valid), '0);
    chk("rst_rsp_line", rsp_line, '0);
    rst = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    tick();
    chk("ready_after_rst", line_t'(req_ready), line_t'(1));
  endtask

  // Called with ready high, one time unit after an edge
  task automatic do_write(input line_addr_t addr, input line_t line);
    req_valid  = 1'b1;
    req_hwrite = 1'b1;
    req_addr   = addr;
    req_line   = line;
    req_hsize  = 3'd4;
    req_hprot  = 2'd1;
    tick();
    req_valid = 1'b0;
    req_line  = '0;
    chk("wr_ready_low0", line_t'(req_ready), '0);
    for (int i = 1; i < int'(WR_LAT); i++) begin
      tick();
      chk("wr_ready_low", line_t'(req_ready), '0);
    end
    tick();
    chk("wr_ready_back", line_t'(req_ready), line_t'(1));
    exp_wr++;
  endtask

  task automatic do_read(input line_addr_t addr, input line_t exp, input int hold);
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_hwrite = 1'b0;
    req_addr   = addr;
    req_line   = '1;
    tick();
    req_valid = 1'b0;
    chk("rd_wait_valid0", line_t'(rsp_valid), '0);
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tick();
      chk("rd_wait_valid", line_t'(rsp_valid), '0);
      chk("rd_wait_ready", line_t'(req_ready), '0);
    end
    tick();
    chk("rd_rsp_valid", line_t'(rsp_valid), line_t'(1));
    chk("rd_rsp_line", rsp_line, exp);
    for (int i = 0; i < hold; i++) begin
      req_valid  = (i == 0);
      req_hwrite = 1'b1;
      req_addr   = addr;
      req_line   = '1;
      tick();
      chk("bp_valid", line_t'(rsp_valid), line_t'(1));
      chk("bp_line", rsp_line, exp);
      chk("bp_ready", line_t'(req_ready), '0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_valid_drop", line_t'(rsp_valid), '0);
    chk("hs_ready_back", line_t'(req_ready), line_t'(1));
    exp_rd++;
  endtask

  task automatic chk_stats();
`ifdef LLC_MEM_RSP_STATS_EN
    chk("rd_count", line_t'(rd_count), line_t'(exp_rd));
    chk("wr_count", line_t'(wr_count), line_t'(exp_wr));
`endif
  endtask

  initial begin
    line_t pat_a5;
    int    seen;
    pat_a5     = {16{8'hA5}};
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_hwrite = 1'b0;
    req_hsize  = '0;
    req_hprot  = '0;
    req_addr   = '0;
    req_line   = '0;
    rsp_ready  = 1'b0;

    do_reset();
    do_read(16'h0010, '0, 0);
    do_write(16'h0010, pat_a5);
    do_read(16'h0010, pat_a5, 0);
    // 0x110 aliases index 0x10 with 256 lines
    do_write(16'h0110, line_t'(16'h1234));
    do_read(16'h0010, line_t'(16'h1234), 0);
    do_read(16'h0010, line_t'(16'h1234), 10);
    do_write(16'h0020, line_t'(64'hDEAD_BEEF_0BAD_F00D));
    do_read(16'h0021, '0, 0);
    do_read(16'h0120, line_t'(64'hDEAD_BEEF_0BAD_F00D), 0);
    chk_stats();

    // Reset while a read is waiting: response must never appear
    req_valid  = 1'b1;
    req_hwrite = 1'b0;
    req_addr   = 16'h0020;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready", line_t'(req_ready), '0);
    rst    = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    seen   = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    rsp_ready = 1'b0;
    chk("midrst_no_rsp", line_t'(seen), '0);
    chk("midrst_ready_back", line_t'(req_ready), line_t'(1));
    chk_stats();
    do_read(16'h0020, '0, 0);
    do_read(16'h0010, '0, 0);
    do_write(16'h0005, line_t'(32'hCAFE_0001));
    do_read(16'h0005, line_t'(32'hCAFE_0001), 0);
    chk_stats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
